// File: rtl/fir_filter.sv
// 31-tap moving-average FIR for a strobed signed audio stream.
// Strobe rising edge shifts the delay line; the next clock registers the saturated result.
`timescale 1ns/1ps
module fir_filter #(
   parameter int                 N = 31,
   parameter int                 M = 24,
   parameter logic signed [15:0] C = 16'sd1057
) (
   input  logic                ck,
   input  logic                rst,
   input  logic signed [M-1:0] in,
   input  logic                input_ready,
   output logic signed [M-1:0] out,
   output logic                output_ready
);

   localparam int ACC_W = M + 16 + $clog2(N);
   localparam logic signed [ACC_W-1:0] MAXV = {{(ACC_W-M+1){1'b0}}, {(M-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] MINV = {{(ACC_W-M+1){1'b1}}, {(M-1){1'b0}}};

   logic signed [M-1:0]     delay_q [N];
   logic                    ready_q;
   logic                    valid_q;
   logic signed [M-1:0]     out_q;
   logic                    out_ready_q;

   logic                    accept;
   logic signed [ACC_W-1:0] acc_d;
   logic signed [ACC_W-1:0] shifted_d;
   logic signed [M-1:0]     out_d;

   // Accept only the first clock of a strobe; the full-width sum cannot overflow.
   always_comb begin
      accept = input_ready & ~ready_q;
      acc_d  = '0;
      for (int k = 0; k < N; k++) begin
         acc_d = acc_d + ACC_W'(delay_q[k]) * ACC_W'(C);
      end
      shifted_d = acc_d >>> 15;
      if (shifted_d > MAXV) begin
         out_d = MAXV[M-1:0];
      end else if (shifted_d < MINV) begin
         out_d = MINV[M-1:0];
      end else begin
         out_d = shifted_d[M-1:0];
      end
   end

   always_ff @(posedge ck) begin
      if (rst) begin
         for (int k = 0; k < N; k++) begin
            delay_q[k] <= '0;
         end
         ready_q     <= 1'b0;
         valid_q     <= 1'b0;
         out_q       <= '0;
         out_ready_q <= 1'b0;
      end else begin
         ready_q     <= input_ready;
         valid_q     <= accept;
         out_ready_q <= valid_q;
         if (accept) begin
            for (int k = N - 1; k > 0; k--) begin
               delay_q[k] <= delay_q[k-1];
            end
            delay_q[0] <= in;
         end
         // The sum is taken from the line as it stood after the accepting edge.
         if (valid_q) begin
            out_q <= out_d;
         end
      end
   end

   assign out          = out_q;
   assign output_ready = out_ready_q;

endmodule

// File: tb/tb_fir_filter.sv
// Randomized self-checking bench for fir_filter against a queue-based
// moving-average model computed with plain integer arithmetic.
`timescale 1ns/1ps
module tb_fir_filter;

   logic               ck;
   logic               rst;
   logic signed [23:0] in;
   logic               input_ready;
   logic signed [23:0] out;
   logic               output_ready;

   int     checks   = 0;
   int     failures = 0;
   longint hist[$];
   longint lastExpected = 0;

   fir_filter dut (
      .ck          (ck),
      .rst         (rst),
      .in          (in),
      .input_ready (input_ready),
      .out         (out),
      .output_ready(output_ready)
   );

   initial ck = 1'b0;
   always #5 ck = ~ck;

   task automatic checkOutput(input string tag, input longint observed, input longint expected);
      checks++;
      if (observed !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
      end
   endtask

   // Reference: sum of the last 31 samples times 1057, floored by 2^15, saturated.
   function automatic longint modelOut();
      longint sum = 0;
      longint y;
      foreach (hist[i]) sum += hist[i];
      y = (sum * 1057) >>> 15;
      if (y > 8388607) y = 8388607;
      if (y < -8388608) y = -8388608;
      return y;
   endfunction

   // Called #1 after a rising edge with input_ready low for at least one prior edge.
   task automatic applyStimulus(input string tag, input logic signed [23:0] sample,
                                input int hold, input int low);
      int     pulses = 0;
      int     pulseCycle = -1;
      longint seen = 0;
      hist.push_front(longint'(sample));
      if (hist.size() > 31) void'(hist.pop_back());
      lastExpected = modelOut();
      in = sample;
      input_ready = 1'b1;
      for (int c = 1; c <= hold + low; c++) begin
         @(posedge ck); #1;
         in = 24'($urandom);
         if (c == hold) input_ready = 1'b0;
         if (output_ready) begin
            pulses++;
            pulseCycle = c;
            seen = longint'(out);
         end
      end
      checkOutput({tag, "_pulses"}, pulses, 1);
      checkOutput({tag, "_latency"}, pulseCycle, 2);
      checkOutput({tag, "_out"}, seen, lastExpected);
      checkOutput({tag, "_hold"}, longint'(out), lastExpected);
   endtask

   task automatic noPulseFor(input string tag, input int n);
      int pulses = 0;
      for (int c = 0; c < n; c++) begin
         @(posedge ck); #1;
         if (output_ready) pulses++;
      end
      checkOutput(tag, pulses, 0);
   endtask

   initial begin
      rst = 1'b1;
      input_ready = 1'b0;
      in = '0;
      repeat (2) @(posedge ck);
      #1;
      checkOutput("reset_out", longint'(out), 0);
      checkOutput("reset_ready", longint'(output_ready), 0);
      rst = 1'b0;
      @(posedge ck); #1;

      for (int i = 0; i < 3; i++) applyStimulus("zero", 24'sd0, 1, 3);

      applyStimulus("impulse", 24'sd10000, 1, 2);
      checkOutput("impulse_first", longint'(out), 322);
      for (int i = 0; i < 40; i++) applyStimulus("impulse_tail", 24'sd0, 1, 1);
      checkOutput("impulse_end", longint'(out), 0);

      for (int i = 0; i < 35; i++) applyStimulus("step", 24'sd10000, 1, 1);
      checkOutput("step_settled", longint'(out), 9999);

      for (int p = 0; p < 4; p++) begin
         for (int i = 0; i < 8; i++) applyStimulus("square", (p % 2 == 0) ? 24'sd10000 : -24'sd10000, 1, 24);
      end

      applyStimulus("long_strobe", 24'sd12345, 5, 2);

      for (int i = 0; i < 31; i++) applyStimulus("max", 24'sd8388607, 1, 1);
      for (int i = 0; i < 31; i++) applyStimulus("min", -24'sd8388608, 1, 1);
      checkOutput("min_settled", longint'(out), -8388352);

      for (int i = 0; i < 60; i++) begin
         logic signed [23:0] s;
         s = ($urandom_range(0, 1) == 1) ? 24'($urandom) : 24'($signed(12'($urandom)));
         applyStimulus("random", s, int'($urandom_range(1, 5)), int'($urandom_range(1, 12)));
      end

      // Strobe coincident with reset must be dropped.
      rst = 1'b1;
      input_ready = 1'b1;
      in = 24'sd7777;
      @(posedge ck); #1;
      rst = 1'b0;
      input_ready = 1'b0;
      hist.delete();
      noPulseFor("rst_strobe_nopulse", 3);
      applyStimulus("after_rst_strobe", 24'sd0, 1, 2);

      // Reset between the accepting edge and the result edge cancels the output.
      applyStimulus("pre_abort", 24'sd5000, 1, 2);
      in = 24'sd5000;
      input_ready = 1'b1;
      @(posedge ck); #1;
      rst = 1'b1;
      input_ready = 1'b0;
      @(posedge ck); #1;
      checkOutput("abort_ready", longint'(output_ready), 0);
      rst = 1'b0;
      hist.delete();
      noPulseFor("abort_nopulse", 3);
      checkOutput("abort_out_cleared", longint'(out), 0);
      applyStimulus("after_abort", 24'sd0, 1, 2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
